// File: rtl/led_select_if.sv
// Bus between the raw front-panel inputs and the LED select stage.
// Groups the buttons, the auto-scan switch and the one-hot select outputs.
interface led_select_if;
  logic       BTN_NEXT;
  logic       BTN_PREV;
  logic       AUTO;
  logic [4:0] SLCT;
  logic       STEP;

  modport master (
    output BTN_NEXT,
    output BTN_PREV,
    output AUTO,
    input  SLCT,
    input  STEP
  );

  modport slave (
    input  BTN_NEXT,
    input  BTN_PREV,
    input  AUTO,
    output SLCT,
    output STEP
  );
endinterface

// File: rtl/led_select.sv
// Synchronizes and debounces two push-buttons plus an auto-scan switch and
// rotates a 5-bit one-hot select on each press or prescaler tick.
module led_select #(
  parameter int DB_CYCLES = 4,
  parameter int AUTO_DIV  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  led_select_if.slave io
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_DIV - 1);

  // bit 0 = next button, bit 1 = prev button, bit 2 = auto switch
  logic [2:0] raw_in;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  logic [1:0] deb;
  logic [1:0] deb_q_reg;
  logic [1:0] press;

  logic          auto_on;
  logic [PW-1:0] pre_reg;
  logic [PW-1:0] pre_next;

  logic [4:0] slct_reg;
  logic [4:0] slct_next;
  logic       step_reg;
  logic       step_next;
  logic       step_evt;
  logic       rot_left;
  logic       is_onehot;

  assign raw_in = {io.AUTO, io.BTN_PREV, io.BTN_NEXT};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg <= 3'b000;
      sync2_reg <= 3'b000;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic          deb_reg;
      logic [CW-1:0] cnt_reg;

      // Any return to the current debounced level restarts the stability count.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          deb_reg <= 1'b0;
          cnt_reg <= '0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign deb[gi]   = deb_reg;
      assign press[gi] = deb_reg & ~deb_q_reg[gi];
    end
  endgenerate

  // Edge detector keeps tracking in auto mode so a held button stays silent.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      deb_q_reg <= 2'b00;
    end else begin
      deb_q_reg <= deb;
    end
  end

  assign auto_on = sync2_reg[2];

  always_comb begin
    pre_next = '0;
    if (auto_on) begin
      pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end

  assign is_onehot = (slct_reg != 5'b00000) &&
                     ((slct_reg & (slct_reg - 5'b00001)) == 5'b00000);

  // Simultaneous next and prev presses cancel out.
  always_comb begin
    step_evt = 1'b0;
    rot_left = 1'b1;
    if (auto_on) begin
      step_evt = (pre_reg == PRE_LAST);
    end else if (press[0] ^ press[1]) begin
      step_evt = 1'b1;
      rot_left = press[0];
    end
  end

  always_comb begin
    slct_next = slct_reg;
    step_next = step_evt;
    if (step_evt) begin
      if (!is_onehot) begin
        slct_next = 5'b00001;
      end else if (rot_left) begin
        slct_next = {slct_reg[3:0], slct_reg[4]};
      end else begin
        slct_next = {slct_reg[0], slct_reg[4:1]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slct_reg <= 5'b00001;
      step_reg <= 1'b0;
    end else begin
      slct_reg <= slct_next;
      step_reg <= step_next;
    end
  end

  assign io.SLCT = slct_reg;
  assign io.STEP = step_reg;

endmodule

// File: tb/tb_led_select.sv
// Directed bench for led_select: button debounce/rotation, glitch rejection,
// auto-scan timing and asynchronous reset in the middle of counts.
module tb_led_select;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  led_select_if bus ();

  led_select #(
    .DB_CYCLES (4),
    .AUTO_DIV  (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_btn(input int sel, input logic v);
    if (sel == 1 || sel == 3) bus.BTN_NEXT = v;
    if (sel == 2 || sel == 3) bus.BTN_PREV = v;
  endtask

  task automatic do_reset();
    RST          = 1'b0;
    bus.BTN_NEXT = 1'b0;
    bus.BTN_PREV = 1'b0;
    bus.AUTO     = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // Drives pat[0..len-1] on the selected button(s), then 12 idle cycles.
  task automatic run_pattern(input logic [15:0] pat, input int len,
                             input int sel, output int steps);
    steps = 0;
    for (int i = 0; i < len; i++) begin
      set_btn(sel, pat[i]);
      tick();
      if (bus.STEP === 1'b1) steps++;
    end
    set_btn(sel, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.STEP === 1'b1) steps++;
    end
  endtask

  task automatic test_reset();
    RST          = 1'b0;
    bus.BTN_NEXT = 1'b0;
    bus.BTN_PREV = 1'b0;
    bus.AUTO     = 1'b0;
    tick();
    tests++;
    if ({bus.SLCT, bus.STEP} !== 6'b000010) begin
      fails++;
      $display("FAIL reset_hold: got slct=%b step=%b want slct=00001 step=0", bus.SLCT, bus.STEP);
    end
    RST = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      tests++;
      if ({bus.SLCT, bus.STEP} !== 6'b000010) begin
        fails++;
        $display("FAIL reset_idle c%0d: got slct=%b step=%b want slct=00001 step=0", c, bus.SLCT, bus.STEP);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_next();
    logic [4:0] exp_slct;
    int         steps;
    do_reset();
    bus.BTN_NEXT = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_slct = (e >= 7) ? 5'b00010 : 5'b00001;
      tests++;
      if (bus.SLCT !== exp_slct || bus.STEP !== (e == 7)) begin
        fails++;
        $display("FAIL next_latency e%0d: got slct=%b step=%b want slct=%b step=%0d",
                 e, bus.SLCT, bus.STEP, exp_slct, (e == 7));
      end
    end
    bus.BTN_NEXT = 1'b0;
    repeat (12) tick();
    exp_slct = 5'b00010;
    for (int p = 2; p <= 5; p++) begin
      run_pattern(16'h03FF, 10, 1, steps);
      exp_slct = {exp_slct[3:0], exp_slct[4]};
      tests++;
      if (bus.SLCT !== exp_slct || steps != 1) begin
        fails++;
        $display("FAIL next_press%0d: got slct=%b steps=%0d want slct=%b steps=1", p, bus.SLCT, steps, exp_slct);
      end
    end
    $display("[TB] test_next done slct=%b", bus.SLCT);
  endtask

  task automatic test_prev_both();
    int steps;
    do_reset();
    run_pattern(16'h03FF, 10, 2, steps);
    tests++;
    if (bus.SLCT !== 5'b10000 || steps != 1) begin
      fails++;
      $display("FAIL prev_wrap: got slct=%b steps=%0d want slct=10000 steps=1", bus.SLCT, steps);
    end
    run_pattern(16'h03FF, 10, 3, steps);
    tests++;
    if (bus.SLCT !== 5'b10000 || steps != 0) begin
      fails++;
      $display("FAIL both_cancel: got slct=%b steps=%0d want slct=10000 steps=0", bus.SLCT, steps);
    end
    $display("[TB] test_prev_both done slct=%b", bus.SLCT);
  endtask

  task automatic test_glitch();
    int steps;
    do_reset();
    run_pattern(16'h0007, 3, 1, steps);
    tests++;
    if (bus.SLCT !== 5'b00001 || steps != 0) begin
      fails++;
      $display("FAIL glitch3: got slct=%b steps=%0d want slct=00001 steps=0", bus.SLCT, steps);
    end
    run_pattern(16'h003B, 7, 1, steps);
    tests++;
    if (bus.SLCT !== 5'b00001 || steps != 0) begin
      fails++;
      $display("FAIL bounce: got slct=%b steps=%0d want slct=00001 steps=0", bus.SLCT, steps);
    end
    run_pattern(16'h000F, 4, 1, steps);
    tests++;
    if (bus.SLCT !== 5'b00010 || steps != 1) begin
      fails++;
      $display("FAIL pulse4: got slct=%b steps=%0d want slct=00010 steps=1", bus.SLCT, steps);
    end
    $display("[TB] test_glitch done slct=%b", bus.SLCT);
  endtask

  task automatic test_auto();
    logic [4:0] exp_slct;
    logic       exp_step;
    int         steps;
    do_reset();
    bus.AUTO = 1'b1;
    exp_slct = 5'b00001;
    for (int e = 1; e <= 45; e++) begin
      if (e == 14) bus.BTN_PREV = 1'b1;
      if (e == 24) bus.BTN_PREV = 1'b0;
      if (e == 35) bus.BTN_NEXT = 1'b1;
      tick();
      exp_step = (e >= 10) && (((e - 10) % 8) == 0);
      if (exp_step) exp_slct = {exp_slct[3:0], exp_slct[4]};
      tests++;
      if (bus.SLCT !== exp_slct || bus.STEP !== exp_step) begin
        fails++;
        $display("FAIL auto e%0d: got slct=%b step=%b want slct=%b step=%b",
                 e, bus.SLCT, bus.STEP, exp_slct, exp_step);
      end
    end
    bus.AUTO = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests++;
      if ({bus.SLCT, bus.STEP} !== 6'b000010) begin
        fails++;
        $display("FAIL auto_exit_held c%0d: got slct=%b step=%b want slct=00001 step=0", c, bus.SLCT, bus.STEP);
      end
    end
    bus.BTN_NEXT = 1'b0;
    repeat (12) tick();
    run_pattern(16'h03FF, 10, 1, steps);
    tests++;
    if (bus.SLCT !== 5'b00010 || steps != 1) begin
      fails++;
      $display("FAIL auto_repress: got slct=%b steps=%0d want slct=00010 steps=1", bus.SLCT, steps);
    end
    $display("[TB] test_auto done slct=%b", bus.SLCT);
  endtask

  task automatic test_reset_mid();
    int steps;
    do_reset();
    run_pattern(16'h03FF, 10, 1, steps);
    bus.BTN_NEXT = 1'b1;
    repeat (5) tick();
    RST = 1'b0;
    #1;
    tests++;
    if ({bus.SLCT, bus.STEP} !== 6'b000010) begin
      fails++;
      $display("FAIL rst_mid_deb: got slct=%b step=%b want slct=00001 step=0", bus.SLCT, bus.STEP);
    end
    tick();
    RST = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      tests++;
      if (bus.SLCT !== ((e >= 7) ? 5'b00010 : 5'b00001) || bus.STEP !== (e == 7)) begin
        fails++;
        $display("FAIL rst_deb_relatency e%0d: got slct=%b step=%b", e, bus.SLCT, bus.STEP);
      end
    end
    bus.BTN_NEXT = 1'b0;
    repeat (12) tick();

    do_reset();
    bus.AUTO = 1'b1;
    repeat (15) tick();
    tests++;
    if (bus.SLCT !== 5'b00010) begin
      fails++;
      $display("FAIL rst_pre_setup: got slct=%b want slct=00010", bus.SLCT);
    end
    RST = 1'b0;
    #1;
    tests++;
    if ({bus.SLCT, bus.STEP} !== 6'b000010) begin
      fails++;
      $display("FAIL rst_mid_pre: got slct=%b step=%b want slct=00001 step=0", bus.SLCT, bus.STEP);
    end
    tick();
    RST = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      tests++;
      if (bus.SLCT !== ((e >= 10) ? 5'b00010 : 5'b00001) || bus.STEP !== (e == 10)) begin
        fails++;
        $display("FAIL rst_pre_relatency e%0d: got slct=%b step=%b", e, bus.SLCT, bus.STEP);
      end
    end
    bus.AUTO = 1'b0;
    $display("[TB] test_reset_mid done slct=%b", bus.SLCT);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    RST          = 1'b0;
    bus.BTN_NEXT = 1'b0;
    bus.BTN_PREV = 1'b0;
    bus.AUTO     = 1'b0;
    test_reset();
    test_next();
    test_prev_both();
    test_glitch();
    test_auto();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_select.md
# led_select

Input stage for the LED demo: turns two raw push-buttons and an auto-scan switch into the 5-bit one-hot select that drives the LED decoder. It synchronizes and debounces the buttons, rotates a one-hot selection register forward or backward on each debounced press, and can step the selection automatically from a prescaler. `SLCT` connects directly to the decoder's `SLCT` input.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles needed before a debounced button changes state (≥ 2).
- `AUTO_DIV`, default 8: clock cycles per automatic step in auto mode (≥ 2).

Ports:
- `CLK`  in  1  single clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `BTN_NEXT`  in  1  raw button, active-high, asynchronous to `CLK`.
- `BTN_PREV`  in  1  raw button, active-high, asynchronous to `CLK`.
- `AUTO`  in  1  level switch, asynchronous; 1 selects auto-scan.
- `SLCT`  out  5  one-hot selection, registered.
- `STEP`  out  1  one-cycle pulse, registered, high in the cycle after every `SLCT` change.

## Operation
- Reset (`RST`=0, immediate): `SLCT`=5'b00001; `STEP`=0. All synchronizers, debounced states, debounce counters and the prescaler clear to 0.
- Synchronizers: each of `BTN_NEXT`, `BTN_PREV` and `AUTO` passes through two flops (sync1, sync2).
- Debouncer, one per button, with debounced state `deb` and counter `cnt`:
  - If sync2 == `deb`: `cnt` <= 0.
  - Else if `cnt` == `DB_CYCLES`-1: `deb` <= sync2 and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - The counter width is clog2(`DB_CYCLES`). Any bounce back to `deb` restarts the count.
- Press detect: `press` = `deb` & ~`deb_q`, where `deb_q` is `deb` delayed one cycle. Releases cause no action.
- Manual mode (auto_sync2=0):
  - `press_next` only: rotate left; bit 4 wraps to bit 0 (10000→00001).
  - `press_prev` only: rotate right; bit 0 wraps to bit 4 (00001→10000).
  - Both in the same cycle: no change and no `STEP`.
  - The prescaler is held at 0.
- Auto mode (auto_sync2=1):
  - The prescaler counts 0..`AUTO_DIV`-1 and wraps.
  - On the cycle it equals `AUTO_DIV`-1, `SLCT` rotates left.
  - Button presses are ignored, but the debouncers keep running. A button held across the switch back to manual produces no press until it is released and pressed again.
- `STEP` <= 1 exactly on edges where `SLCT` is loaded with a new value; otherwise 0.
- Robustness: if `SLCT` is ever not one-hot, the next step event loads 5'b00001 instead of rotating.

## Timing
- Button latency: count the first rising edge that samples the raw button high as edge 1.
  - sync2 goes high at edge 2.
  - `deb` goes high at edge `DB_CYCLES`+2.
  - `SLCT` and `STEP` update at edge `DB_CYCLES`+3 (edge 7 at default).
- Glitch rejection: a pulse stable for fewer than `DB_CYCLES` cycles after synchronization never changes `deb`.
- Minimum press spacing: each press needs a debounced release and a debounced re-press, so at least 2×`DB_CYCLES` cycles.
- Auto mode:
  - `AUTO` rises before edge 1; auto_sync2=1 from edge 2.
  - The prescaler counts from edge 3 and the first rotation happens at edge `AUTO_DIV`+2.
  - After that, one rotation every `AUTO_DIV` cycles.
  - Dropping `AUTO` clears the prescaler 2 cycles later. Re-entering auto mode restarts the full period.
- `STEP` is high for exactly one cycle per change; back-to-back changes give `STEP` high on consecutive cycles.
- Reset mid-debounce or mid-prescale discards all partial counts; `SLCT` returns to 00001 asynchronously.

## Test plan
- Reset then idle 20 cycles → `SLCT`=00001 and `STEP`=0 throughout.
- `BTN_NEXT` high from edge 1 for 10 cycles (`DB_CYCLES`=4) → `SLCT` 00001→00010 at edge 7 and `STEP` high for that cycle only. Five clean next presses total → 00010, 00100, 01000, 10000, 00001.
- From reset, one clean `BTN_PREV` press → `SLCT`=10000. Then `BTN_NEXT` and `BTN_PREV` rising on the same edge and held → `SLCT` stays 10000, no `STEP`.
- `BTN_NEXT` 3-cycle glitch, and separately a bouncing pattern 1,1,0,1,1,1,0 → no `SLCT` change, no `STEP`.
- `AUTO`=1 with `AUTO_DIV`=8 → rotations at edges 10, 18, 26, ... through all five positions and wrap. A `BTN_PREV` press during auto mode is ignored.
- Assert `RST` at edge 5 of a debounce in progress and at prescaler=5 in auto mode → `SLCT`=00001 immediately. After release, a full `DB_CYCLES`+3 or `AUTO_DIV`+2 latency is required again.
